// File: rtl/mips_mc_ctrl_pkg.sv
// mips_mc_ctrl_pkg: shared states, opcode/func codes and control-field encodings for the multi-cycle MIPS controller
package mips_mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IF, S_ID, S_EXE_R, S_WB_R, S_J, S_BEQ, S_BNE, S_JR,
        S_JAL, S_MEM_ADDR, S_SW, S_LW_RD, S_LW_WB, S_IMM_EXE, S_IMM_WB, S_TRAP
    } state_t;

    typedef enum logic [2:0] {C_ADD, C_SUB, C_FUNC, C_AND, C_OR, C_SLT} alu_cls_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JR    = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_4     = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIMM = 2'b11;

    localparam logic [1:0] DST_RT  = 2'b00;
    localparam logic [1:0] DST_RD  = 2'b01;
    localparam logic [1:0] DST_R31 = 2'b10;

endpackage

// File: rtl/mips_alu_dec.sv
// mips_alu_dec: maps an ALU operation class plus R-type func to alu_ctl and flags unsupported func codes
module mips_alu_dec
    import mips_mc_ctrl_pkg::*;
(
    input  alu_cls_t    cls,
    input  logic [5:0]  func,
    output logic [2:0]  alu_ctl,
    output logic        func_valid
);

    logic [2:0] func_ctl;

    // R-type func decode; unsupported codes fall back to ADD and drop func_valid
    always_comb begin
        func_ctl   = ALU_ADD;
        func_valid = 1'b1;
        case (func)
            F_ADD:   func_ctl = ALU_ADD;
            F_SUB:   func_ctl = ALU_SUB;
            F_AND:   func_ctl = ALU_AND;
            F_OR:    func_ctl = ALU_OR;
            F_SLT:   func_ctl = ALU_SLT;
            default: func_valid = 1'b0;
        endcase
    end

    // class selects a fixed operation or defers to the func decode
    always_comb begin
        alu_ctl = cls == C_SUB  ? ALU_SUB :
                  cls == C_FUNC ? func_ctl :
                  cls == C_AND  ? ALU_AND :
                  cls == C_OR   ? ALU_OR :
                  cls == C_SLT  ? ALU_SLT : ALU_ADD;
    end

endmodule

// File: rtl/mips_mc_ctrl_hs.sv
// mips_mc_ctrl_hs: multi-cycle MIPS control FSM with ready/valid memory stalls; MIPS_MC_CTRL_TIMEOUT_EN adds a memory-wait bus-error trap
module mips_mc_ctrl_hs
    import mips_mc_ctrl_pkg::*;
#(
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 15
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctl,
    output logic [1:0] reg_dst,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       link,
    output logic       instr_done,
    output logic       illegal,
    output logic       bus_err,
    output logic [3:0] state
);

    state_t     st;
    alu_cls_t   cls;
    logic [2:0] dec_ctl;
    logic       func_valid;
    logic       mem_st;

    assign state  = st;
    assign mem_st = st == S_IF || st == S_SW || st == S_LW_RD;
    assign cls    = st == S_EXE_R ? C_FUNC :
                    (st == S_BEQ || st == S_BNE) ? C_SUB :
                    st != S_IMM_EXE ? C_ADD :
                    opcode == OP_ANDI ? C_AND :
                    opcode == OP_ORI  ? C_OR :
                    opcode == OP_SLTI ? C_SLT : C_ADD;

    mips_alu_dec u_alu_dec (
        .cls        (cls),
        .func       (func),
        .alu_ctl    (dec_ctl),
        .func_valid (func_valid)
    );

`ifdef MIPS_MC_CTRL_TIMEOUT_EN
    logic [WAIT_W-1:0] wcnt;
`else
    assign bus_err = 1'b0;
`endif

    // state sequencing, sticky trap flags and the optional memory-wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= S_IF;
            illegal <= 1'b0;
`ifdef MIPS_MC_CTRL_TIMEOUT_EN
            bus_err <= 1'b0;
            wcnt    <= '0;
`endif
        end else begin
            case (st)
                S_IF:       if (mem_ready) st <= S_ID;
                S_ID: begin
                    case (opcode)
                        OP_RTYPE:                          st <= S_EXE_R;
                        OP_BEQ:                            st <= S_BEQ;
                        OP_BNE:                            st <= S_BNE;
                        OP_LW, OP_SW:                      st <= S_MEM_ADDR;
                        OP_J:                              st <= S_J;
                        OP_JAL:                            st <= S_JAL;
                        OP_JR:                             st <= S_JR;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: st <= S_IMM_EXE;
                        default: begin
                            st      <= S_TRAP;
                            illegal <= 1'b1;
                        end
                    endcase
                end
                S_EXE_R: begin
                    st      <= func_valid ? S_WB_R : S_TRAP;
                    illegal <= illegal | ~func_valid;
                end
                S_MEM_ADDR: st <= opcode == OP_SW ? S_SW : S_LW_RD;
                S_SW:       if (mem_ready) st <= S_IF;
                S_LW_RD:    if (mem_ready) st <= S_LW_WB;
                S_IMM_EXE:  st <= S_IMM_WB;
                S_TRAP:     st <= S_TRAP;
                default:    st <= S_IF;
            endcase
`ifdef MIPS_MC_CTRL_TIMEOUT_EN
            if (mem_st) begin
                if (mem_ready) begin
                    wcnt <= '0;
                end else if (wcnt == WAIT_W'(MAX_WAIT)) begin
                    wcnt    <= '0;
                    st      <= S_TRAP;
                    bus_err <= 1'b1;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end
`endif
        end
    end

    // Moore control decode; IF write strobes and the SW done pulse follow mem_ready
    always_comb begin
        mem_req       = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_src        = PC_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RT;
        alu_ctl       = st == S_TRAP ? 3'b000 : dec_ctl;
        reg_dst       = DST_RT;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        link          = 1'b0;
        instr_done    = 1'b0;
        case (st)
            S_IF: begin
                mem_req   = 1'b1;
                mem_read  = 1'b1;
                alu_src_b = SRCB_4;
                ir_write  = mem_ready & ~rst;
                pc_write  = mem_ready & ~rst;
            end
            S_ID:       alu_src_b = SRCB_SHIMM;
            S_EXE_R:    alu_src_a = 1'b1;
            S_WB_R: begin
                reg_dst    = DST_RD;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ, S_BNE: begin
                alu_src_a     = 1'b1;
                pc_src        = PC_ALUOUT;
                pc_write_cond = 1'b1;
                branch_ne     = st == S_BNE;
                instr_done    = 1'b1;
            end
            S_J, S_JR: begin
                pc_src     = st == S_J ? PC_JUMP : PC_RS;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            S_JAL: begin
                pc_src     = PC_JUMP;
                pc_write   = 1'b1;
                link       = 1'b1;
                reg_dst    = DST_R31;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_ADDR, S_IMM_EXE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_SW: begin
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_LW_RD: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_LW_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_IMM_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_mc_ctrl_hs.sv
// tb_mips_mc_ctrl_hs: scoreboard bench; per-cycle expected state/controls queued at drive time, compared at negedge
module tb_mips_mc_ctrl_hs;
    import mips_mc_ctrl_pkg::*;

    localparam int MAXW = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'b0;
    logic [5:0] func = 6'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, branch_ne;
    logic [1:0] pc_src, alu_src_b, reg_dst;
    logic       alu_src_a, reg_write, mem_to_reg, link, instr_done, illegal, bus_err;
    logic [2:0] alu_ctl;
    logic [3:0] state;

    always #5 clk = ~clk;

    mips_mc_ctrl_hs #(.WAIT_W(4), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .branch_ne(branch_ne), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_ctl(alu_ctl), .reg_dst(reg_dst), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .link(link), .instr_done(instr_done), .illegal(illegal), .bus_err(bus_err), .state(state)
    );

    typedef struct packed {
        logic [3:0]  st;
        logic [23:0] ctl;
        logic [23:0] mask;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    string       cur_tag = "reset";
    logic [2:0]  xa = 3'b010;
    logic        xa_ok = 1'b1;
    logic        exp_ill = 1'b0;
    logic        exp_be = 1'b0;
    logic [23:0] got_ctl;

    assign got_ctl = {mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, branch_ne,
                      pc_src, alu_src_a, alu_src_b, alu_ctl, reg_dst, reg_write, mem_to_reg, link,
                      instr_done, illegal, bus_err};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] ctl_of(input state_t s, input logic mr, input logic r);
        logic       req, rd, wr, io, irw, pcw, pcc, bn, sa, rw, m2r, lnk, done;
        logic [1:0] ps, sb, dst;
        logic [2:0] ac;
        {req, rd, wr, io, irw, pcw, pcc, bn, sa, rw, m2r, lnk, done} = '0;
        ps = 2'b00; sb = 2'b00; dst = 2'b00; ac = 3'b000;
        case (s)
            S_IF:       begin req = 1; rd = 1; sb = 2'b01; ac = 3'b010; irw = mr & ~r; pcw = mr & ~r; end
            S_ID:       begin sb = 2'b11; ac = 3'b010; end
            S_EXE_R:    begin sa = 1; ac = xa; end
            S_WB_R:     begin dst = 2'b01; rw = 1; done = 1; end
            S_BEQ:      begin sa = 1; ac = 3'b110; ps = 2'b01; pcc = 1; done = 1; end
            S_BNE:      begin sa = 1; ac = 3'b110; ps = 2'b01; pcc = 1; bn = 1; done = 1; end
            S_J:        begin ps = 2'b10; pcw = 1; done = 1; end
            S_JR:       begin ps = 2'b11; pcw = 1; done = 1; end
            S_JAL:      begin ps = 2'b10; pcw = 1; lnk = 1; dst = 2'b10; rw = 1; done = 1; end
            S_MEM_ADDR: begin sa = 1; sb = 2'b10; ac = 3'b010; end
            S_SW:       begin req = 1; wr = 1; io = 1; done = mr; end
            S_LW_RD:    begin req = 1; rd = 1; io = 1; end
            S_LW_WB:    begin m2r = 1; rw = 1; done = 1; end
            S_IMM_EXE:  begin sa = 1; sb = 2'b10; ac = xa; end
            S_IMM_WB:   begin rw = 1; done = 1; end
            default: ;
        endcase
        return {req, rd, wr, io, irw, pcw, pcc, bn, ps, sa, sb, ac, dst, rw, m2r, lnk, done, exp_ill, exp_be};
    endfunction

    // alu_ctl is only defined where the ALU does work (or in TRAP, where it is 0)
    function automatic logic alu_defined(input state_t s);
        return s == S_IF || s == S_ID || s == S_BEQ || s == S_BNE || s == S_MEM_ADDR ||
               s == S_IMM_EXE || s == S_TRAP || (s == S_EXE_R && xa_ok);
    endfunction

    task automatic cyc(input state_t s, input logic mr);
        exp_t e;
        mem_ready = mr;
        e.st   = s;
        e.ctl  = ctl_of(s, mr, rst);
        e.mask = alu_defined(s) ? 24'hFFFFFF : 24'hFFF8FF;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          input logic [2:0] a, input logic ok);
        cur_tag = tag;
        opcode  = op;
        func    = fn;
        xa      = a;
        xa_ok   = ok;
    endtask

    task automatic do_reset();
        cur_tag = "reset";
        rst     = 1'b1;
        exp_ill = 1'b0;
        exp_be  = 1'b0;
        cyc(S_IF, 1'b1);
        cyc(S_IF, 1'b0);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            check({cur_tag, ":state"}, 32'(state), 32'(mon_e.st));
            check({cur_tag, ":ctl"}, 32'(got_ctl & mon_e.mask), 32'(mon_e.ctl & mon_e.mask));
        end
    end

    logic [5:0] rf[5]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] ra[5]  = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    logic [5:0] iop[4] = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};
    logic [2:0] ia[4]  = '{3'b010, 3'b000, 3'b001, 3'b111};

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 5; i++) begin
            set_ir("rtype", 6'b000000, rf[i], ra[i], 1'b1);
            cyc(S_IF, 1); cyc(S_ID, 0); cyc(S_EXE_R, 0); cyc(S_WB_R, 0);
        end

        set_ir("lw_stall", 6'b100011, 6'b0, 3'b010, 1'b1);
        cyc(S_IF, 1); cyc(S_ID, 0); cyc(S_MEM_ADDR, 0);
        cyc(S_LW_RD, 0); cyc(S_LW_RD, 0); cyc(S_LW_RD, 0); cyc(S_LW_RD, 1); cyc(S_LW_WB, 0);

        set_ir("sw_stall", 6'b101011, 6'b0, 3'b010, 1'b1);
        cyc(S_IF, 0); cyc(S_IF, 1); cyc(S_ID, 0); cyc(S_MEM_ADDR, 0); cyc(S_SW, 0); cyc(S_SW, 1);

        set_ir("beq", 6'b000100, 6'b0, 3'b010, 1'b1);
        cyc(S_IF, 1); cyc(S_ID, 0); cyc(S_BEQ, 0);
        set_ir("bne", 6'b000101, 6'b0, 3'b010, 1'b1);
        cyc(S_IF, 1); cyc(S_ID, 0); cyc(S_BNE, 0);
        set_ir("j", 6'b000010, 6'b0, 3'b010, 1'b1);
        cyc(S_IF, 1); cyc(S_ID, 0); cyc(S_J, 0);
        set_ir("jr", 6'b000001, 6'b0, 3'b010, 1'b1);
        cyc(S_IF, 1); cyc(S_ID, 0); cyc(S_JR, 0);
        set_ir("jal", 6'b000011, 6'b0, 3'b010, 1'b1);
        cyc(S_IF, 1); cyc(S_ID, 0); cyc(S_JAL, 0);

        for (int i = 0; i < 4; i++) begin
            set_ir("imm", iop[i], 6'b0, ia[i], 1'b1);
            cyc(S_IF, 1); cyc(S_ID, 0); cyc(S_IMM_EXE, 0); cyc(S_IMM_WB, 0);
        end

        set_ir("bad_func", 6'b000000, 6'b000000, 3'b010, 1'b0);
        cyc(S_IF, 1); cyc(S_ID, 0); cyc(S_EXE_R, 0);
        exp_ill = 1'b1;
        cyc(S_TRAP, 1); cyc(S_TRAP, 0); cyc(S_TRAP, 1);
        do_reset();

        set_ir("bad_op", 6'b111111, 6'b100000, 3'b010, 1'b1);
        cyc(S_IF, 1); cyc(S_ID, 0);
        exp_ill = 1'b1;
        cyc(S_TRAP, 1); cyc(S_TRAP, 0); cyc(S_TRAP, 1); cyc(S_TRAP, 1);
        do_reset();

        set_ir("abort_lw", 6'b100011, 6'b0, 3'b010, 1'b1);
        cyc(S_IF, 1); cyc(S_ID, 1); cyc(S_MEM_ADDR, 1);
        do_reset();
        set_ir("after_abort", 6'b000000, 6'b100000, 3'b010, 1'b1);
        cyc(S_IF, 1); cyc(S_ID, 0); cyc(S_EXE_R, 0); cyc(S_WB_R, 0);

`ifdef MIPS_MC_CTRL_TIMEOUT_EN
        set_ir("timeout", 6'b000000, 6'b100000, 3'b010, 1'b1);
        for (int i = 0; i <= MAXW; i++) cyc(S_IF, 0);
        exp_be = 1'b1;
        cyc(S_TRAP, 1); cyc(S_TRAP, 0);
        do_reset();

        set_ir("late_ready", 6'b000000, 6'b100000, 3'b010, 1'b1);
        for (int i = 0; i < MAXW; i++) cyc(S_IF, 0);
        cyc(S_IF, 1); cyc(S_ID, 0); cyc(S_EXE_R, 0); cyc(S_WB_R, 0);
`else
        set_ir("long_wait", 6'b000000, 6'b100000, 3'b010, 1'b1);
        for (int i = 0; i < MAXW + 5; i++) cyc(S_IF, 0);
        cyc(S_IF, 1); cyc(S_ID, 0); cyc(S_EXE_R, 0); cyc(S_WB_R, 0);
`endif

        @(negedge clk);
        #1;
        check("drain", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
